// File: rtl/spiflash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spiflash_pkg
// Purpose  : Shared types, opcodes and helpers for the serial-flash reader
// Revision : 1.0
// ============================================================================
package spiflash_pkg;

    localparam int ADDR_W = 24;
    localparam int WORD_W = 32;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_PWRUP = 8'hAB;

    typedef enum logic [2:0] {
        ST_PWR_CSH  = 3'd0,
        ST_PWR_CMD  = 3'd1,
        ST_IDLE_CSH = 3'd2,
        ST_IDLE     = 3'd3,
        ST_CMD      = 3'd4,
        ST_DATA     = 3'd5,
        ST_RESP     = 3'd6,
        ST_BURST    = 3'd7
    } state_t;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return a & 24'hFF_FFFC;
    endfunction

    // The flash streams bytes in address order; the CPU wants the first byte in [7:0].
    function automatic logic [WORD_W-1:0] bytes_le(input logic [WORD_W-1:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic cs_active(input state_t s);
        return s inside {ST_PWR_CMD, ST_CMD, ST_DATA, ST_RESP, ST_BURST};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spiflash_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : spiflash_reader_if
// Purpose  : Bus-side read request / response channel of the flash reader
// Revision : 1.0
// ============================================================================
interface spiflash_reader_if;
    import spiflash_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface
`default_nettype wire

// File: rtl/spiflash_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spiflash_shifter
// Purpose  : SPI mode-0 bit engine: sclk divider plus 32-bit tx/rx shifter
// Revision : 1.0
// ============================================================================
module spiflash_shifter
    import spiflash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  wire logic              clk,
    input  wire logic              resetn,
    input  wire logic              start,
    input  wire logic [5:0]        nbits,
    input  wire logic [WORD_W-1:0] tx_data,
    output logic      [WORD_W-1:0] rx_data,
    output logic                   done,
    output logic                   sclk,
    output logic                   mosi,
    input  wire logic              miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);

    logic              r_busy;
    logic              r_sclk;
    logic [DIV_W-1:0]  r_div;
    logic [5:0]        r_bits_left;
    logic [WORD_W-1:0] r_tx;
    logic [WORD_W-1:0] r_rx;
    logic              w_half_end;

    assign w_half_end = (r_div == c_div_last);

    // Combinational so the FSM can chain the next frame with no idle sclk cycle.
    assign done    = r_busy && r_sclk && w_half_end && (r_bits_left == 6'd1);
    assign sclk    = r_sclk;
    assign mosi    = r_busy & r_tx[WORD_W-1];
    assign rx_data = r_rx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy      <= 1'b0;
            r_sclk      <= 1'b0;
            r_div       <= '0;
            r_bits_left <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
        end else if (start) begin
            r_busy      <= 1'b1;
            r_sclk      <= 1'b0;
            r_div       <= '0;
            r_bits_left <= nbits;
            r_tx        <= tx_data;
        end else if (r_busy) begin
            if (!w_half_end) begin
                r_div <= r_div + 1'b1;
            end else begin
                r_div <= '0;
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                    r_rx   <= {r_rx[WORD_W-2:0], miso};
                end else begin
                    r_sclk <= 1'b0;
                    if (r_bits_left == 6'd1) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_bits_left <= r_bits_left - 6'd1;
                        r_tx        <= {r_tx[WORD_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spiflash_reader.sv
`default_nettype none
// ============================================================================
// Module   : spiflash_reader
// Purpose  : SPI flash word fetcher (cmd 0x03) with power-up and burst reuse
// Revision : 1.0
// ============================================================================
module spiflash_reader
    import spiflash_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int CSH_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    spiflash_reader_if.slave   bus,
    output logic               spi_cs,
    output logic               spi_sclk,
    output logic               spi_mosi,
    input  wire logic          spi_miso
);

    localparam int CNT_W = $clog2(CSH_CYCLES + 1);
    // cs-high states last CSH_CYCLES+1 cycles; the extra cycle mirrors the IDLE accept cycle.
    localparam logic [CNT_W-1:0] c_csh_last = CNT_W'(CSH_CYCLES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] r_next_addr;
    logic              r_pending;
    logic              w_pending_nxt;
    logic [WORD_W-1:0] r_rdata;
    logic              r_cs;
    logic              r_ready;
    logic              r_rsp_valid;

    logic              w_sh_start;
    logic [5:0]        w_sh_nbits;
    logic [WORD_W-1:0] w_sh_tx;
    logic [WORD_W-1:0] w_sh_rx;
    logic              w_sh_done;
    logic [ADDR_W-1:0] w_req_al;

    assign w_req_al      = align_word(bus.req_addr);
    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign spi_cs        = r_cs;

    spiflash_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .resetn  (resetn),
        .start   (w_sh_start),
        .nbits   (w_sh_nbits),
        .tx_data (w_sh_tx),
        .rx_data (w_sh_rx),
        .done    (w_sh_done),
        .sclk    (spi_sclk),
        .mosi    (spi_mosi),
        .miso    (spi_miso)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_addr_nxt    = r_addr;
        w_pending_nxt = r_pending;
        w_sh_start    = 1'b0;
        w_sh_nbits    = 6'd32;
        w_sh_tx       = '0;

        case (r_state)
            ST_PWR_CSH: begin
                if (r_cnt == c_csh_last) begin
                    w_sh_start  = 1'b1;
                    w_sh_nbits  = 6'd8;
                    w_sh_tx     = {SPI_CMD_PWRUP, 24'h000000};
                    w_state_nxt = ST_PWR_CMD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PWR_CMD: begin
                if (w_sh_done) begin
                    w_state_nxt = ST_IDLE_CSH;
                end
            end
            ST_IDLE_CSH: begin
                if (r_cnt != c_csh_last) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (r_pending) begin
                    // Non-sequential request taken in BURST: issue its command now.
                    w_sh_start    = 1'b1;
                    w_sh_tx       = {SPI_CMD_READ, r_addr};
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = ST_CMD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_addr_nxt  = w_req_al;
                    w_sh_start  = 1'b1;
                    w_sh_tx     = {SPI_CMD_READ, w_req_al};
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_sh_done) begin
                    w_sh_start  = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_sh_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_BURST;
            end
            ST_BURST: begin
                if (bus.req_valid) begin
                    w_addr_nxt = w_req_al;
                    if (w_req_al == r_next_addr) begin
                        w_sh_start  = 1'b1;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_pending_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE_CSH;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_PWR_CSH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_PWR_CSH;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_next_addr <= '0;
            r_pending   <= 1'b0;
            r_rdata     <= '0;
            r_cs        <= 1'b1;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_pending   <= w_pending_nxt;
            // Pin-level outputs are registered from the next state so they never glitch.
            r_cs        <= ~cs_active(w_state_nxt);
            r_ready     <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_BURST);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            if ((r_state == ST_DATA) && w_sh_done) begin
                r_rdata <= bytes_le(w_sh_rx);
            end
            if (r_state == ST_RESP) begin
                r_next_addr <= r_addr + 24'd4;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spiflash_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spiflash_reader
// Purpose  : Self-checking bench for spiflash_reader with a behavioural flash
// Revision : 1.0
// ============================================================================
module tb_spiflash_reader;
    import spiflash_pkg::*;

    localparam int CLK_DIV    = 2;
    localparam int CSH_CYCLES = 4;
    localparam int LAT_FRESH  = 1 + 128 * CLK_DIV;
    localparam int LAT_BURST  = 1 + 64 * CLK_DIV;
    localparam int LAT_JUMP   = LAT_FRESH + CSH_CYCLES + 1;
    localparam int PWR_MIN    = 2 * CSH_CYCLES + 16 * CLK_DIV + 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic spi_cs, spi_sclk, spi_mosi;
    logic spi_miso = 1'b0;

    spiflash_reader_if bus();

    spiflash_reader #(
        .CLK_DIV    (CLK_DIV),
        .CSH_CYCLES (CSH_CYCLES)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Flash model: byte at address a holds a[7:0]; data streams from the command address.
    int          bitcnt = 0;
    logic [31:0] in_sr = '0;
    logic [23:0] maddr = '0;
    logic [31:0] last_cmd = '0;
    logic [7:0]  first_byte = '0;
    int          cmd_cnt = 0;
    int          frames = 0;
    int          pwr_frames = 0;
    int          last_frame_bits = 0;
    int          mdi;
    logic [23:0] mda;

    always @(posedge spi_sclk or posedge spi_cs) begin
        if (spi_cs) begin
            if (bitcnt > 0) begin
                frames++;
                last_frame_bits = bitcnt;
                if (bitcnt == 8 && first_byte == SPI_CMD_PWRUP) pwr_frames++;
            end
            bitcnt = 0;
        end else begin
            if (bitcnt < 32) in_sr = {in_sr[30:0], spi_mosi};
            bitcnt++;
            if (bitcnt == 8) first_byte = in_sr[7:0];
            if (bitcnt == 32) begin
                maddr    = in_sr[23:0];
                last_cmd = in_sr;
                cmd_cnt++;
            end
        end
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs && bitcnt >= 32) begin
            mdi      = bitcnt - 32;
            mda      = maddr + 24'(mdi / 8);
            spi_miso = mda[7 - (mdi % 8)];
        end
    end

    int hi_run = 0;
    int last_hi_run = 0;
    always @(negedge clk) begin
        if (spi_cs) begin
            hi_run++;
        end else begin
            if (hi_run > 0) last_hi_run = hi_run;
            hi_run = 0;
        end
    end

    typedef struct {
        logic [31:0] data;
        int          due;
        string       tag;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq({e.tag, "_data"}, bus.rsp_rdata, e.data);
                check_eq({e.tag, "_lat"}, cyc, e.due);
            end
        end
    end

    task automatic issue(input logic [23:0] addr, input logic [31:0] exp_data,
                         input int lat, input string tag, input bit expect_rsp);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        n = 0;
        while (!bus.req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        if (expect_rsp) begin
            e.data = exp_data;
            e.due  = cyc + lat;
            e.tag  = tag;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    task automatic pwr_wait(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 500);
        check_eq({tag, "_ready_bound"}, 32'(bus.req_ready && n >= PWR_MIN), 32'd1);
    endtask

    initial begin
        int c0;
        int f0;
        int n;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;

        repeat (4) @(negedge clk);
        check_eq("rst_cs", 32'(spi_cs), 32'd1);
        check_eq("rst_sclk", 32'(spi_sclk), 32'd0);
        check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rdata", bus.rsp_rdata, 32'd0);

        resetn = 1'b1;
        pwr_wait("pwr1");
        check_eq("pwr1_frames", pwr_frames, 32'd1);
        check_eq("pwr1_total_frames", frames, 32'd1);
        check_eq("pwr1_frame_bits", last_frame_bits, 32'd8);
        check_eq("pwr1_opcode", 32'(first_byte), 32'h000000AB);

        c0 = cmd_cnt;
        issue(24'h000010, 32'h13121110, LAT_FRESH, "rd10", 1'b1);
        wait_rsp("rd10");
        check_eq("rd10_cmd", last_cmd, 32'h03000010);
        check_eq("rd10_ncmd", cmd_cnt - c0, 32'd1);

        c0 = cmd_cnt;
        f0 = frames;
        issue(24'h000014, 32'h17161514, LAT_BURST, "rd14", 1'b1);
        wait_rsp("rd14");
        check_eq("rd14_ncmd", cmd_cnt - c0, 32'd0);
        check_eq("rd14_cs_held", frames - f0, 32'd0);
        check_eq("rd14_cs_low", 32'(spi_cs), 32'd0);

        issue(24'h000100, 32'h03020100, LAT_JUMP, "rd100", 1'b1);
        wait_rsp("rd100");
        check_eq("rd100_cmd", last_cmd, 32'h03000100);
        check_eq("rd100_csh_min", 32'(last_hi_run >= CSH_CYCLES), 32'd1);

        issue(24'h000013, 32'h13121110, LAT_JUMP, "rd13", 1'b1);
        wait_rsp("rd13");
        check_eq("rd13_cmd", last_cmd, 32'h03000010);

        issue(24'hFFFFFC, 32'hFFFEFDFC, LAT_JUMP, "rdtop", 1'b1);
        wait_rsp("rdtop");
        check_eq("rdtop_cmd", last_cmd, 32'h03FFFFFC);
        c0 = cmd_cnt;
        issue(24'h000002, 32'h03020100, LAT_BURST, "rdwrap", 1'b1);
        wait_rsp("rdwrap");
        check_eq("rdwrap_ncmd", cmd_cnt - c0, 32'd0);

        // Abort a transfer with reset while the data phase is clocking.
        issue(24'h000200, 32'h0, 0, "rdabort", 1'b0);
        repeat (CSH_CYCLES + 1 + 64 * CLK_DIV + 20) @(negedge clk);
        check_eq("abort_cs_low", 32'(spi_cs), 32'd0);
        n = 0;
        while (!spi_sclk && n < 4 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_sclk_high", 32'(spi_sclk), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("abort_cs", 32'(spi_cs), 32'd1);
        check_eq("abort_sclk", 32'(spi_sclk), 32'd0);
        check_eq("abort_ready", 32'(bus.req_ready), 32'd0);
        check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("abort_rdata", bus.rsp_rdata, 32'd0);

        resetn = 1'b1;
        pwr_wait("pwr2");
        check_eq("pwr2_frames", pwr_frames, 32'd2);

        issue(24'h000010, 32'h13121110, LAT_FRESH, "rdpost", 1'b1);
        wait_rsp("rdpost");
        check_eq("rdpost_cmd", last_cmd, 32'h03000010);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
